dm_lsu: RTL and testbench
=========================

# dm_lsu

Parametrised, handshaked data memory for the MIPS datapath's MEM stage. It generalises the original byte/word store-and-load memory in three ways: full byte, halfword and word access with sign or zero extension on loads; alignment checking; and a configurable wait-state latency behind a valid/ready request port. A hardware clear sequence after reset and a registered write-trace port replace the simulation-only memory wipe and print.

## Interface
Parameters:
- DEPTH, 1024, number of 32-bit words (power of two, ≥4); byte address bits used AW = log2(DEPTH)+2
- WAIT_CYCLES, 0, extra wait states between request acceptance and access (0..15)
- CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting requests

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 reserved
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low-aligned (byte in [7:0], half in [15:0])
- req_pc  in  32  PC of the instruction, for trace only
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores and errors)
- resp_err  out  1  misaligned or reserved-size request, valid with resp_valid
- wr_log_valid  out  1  one-cycle pulse for each committed store
- wr_log_pc  out  32  PC of the committed store
- wr_log_addr  out  32  {req_addr[31:2],2'b00}, unwrapped
- wr_log_data  out  32  full word at that address after the merge

## Operation
- Storage: DEPTH × 32 bits with four byte lanes; the word index is addr[AW-1:2]. Upper address bits are ignored, so addresses wrap modulo 4·DEPTH.
- States:
  - CLEAR: idx steps 0..DEPTH-1, writing one zero word per cycle. The transition to IDLE happens on the edge that writes idx = DEPTH-1.
  - IDLE: req_ready = 1. When req_valid is sampled high, the request fields are latched, cnt ← WAIT_CYCLES and the state moves to WAIT.
  - WAIT: while cnt ≠ 0, cnt decrements each edge. On the edge with cnt == 0, the access is performed, response registers are loaded and the state returns to IDLE.
- Alignment errors: half with addr[0] = 1, word with addr[1:0] ≠ 0, or size 3. The response has resp_err = 1 and resp_rdata = 0; no array write and no log pulse occur.
- Stores: only the addressed lanes are written.
  - byte → lane addr[1:0] ← wdata[7:0]
  - half → lanes {addr[1],1} and {addr[1],0} ← wdata[15:0]
  - word → all lanes
- Loads: the byte is lane addr[1:0] and the half is the lane pair selected by addr[1]. Both are extended per req_unsigned. A word load returns the little-endian word (lane 0 = bits [7:0]).
- The write log reports the merged word: stored lanes take the new data, untouched lanes keep their old contents.
- Memory contents are never changed asynchronously. Reset does not touch the array; only CLEAR writes it.

## Timing
- Reset values: state = CLEAR if CLEAR_ON_RESET, else IDLE; req_ready = 0 when CLEAR_ON_RESET = 1, else 1. resp_valid, resp_err, wr_log_valid = 0; resp_rdata, wr_log_* = 0; cnt = 0; idx = 0.
- The clear phase takes exactly DEPTH cycles after reset is released; req_ready rises in the cycle after the last clear write.
- Latency: a request accepted at edge E produces resp_valid high during the cycle after edge E+1+WAIT_CYCLES. Throughput is one request per 2+WAIT_CYCLES cycles.
- resp_valid and req_ready are both high in the completion cycle, so a back-to-back request may be accepted on that same edge.
- A load following a store to the same word sees the stored data; there is no hazard window.
- req_* inputs are ignored outside IDLE. The response is not back-pressured.
- Reset asserted in WAIT abandons the access (no write, no pulse); a clear then starts. Reset asserted in CLEAR restarts the clear at idx 0.

## Test plan
- CLEAR_ON_RESET = 1, DEPTH = 16, pre-load garbage via stores, then reset → req_ready low for exactly 16 cycles after rst falls; a word load of 0x3C then returns 0.
- WAIT_CYCLES = 0: word store 0x11223344 @0x8, then byte store 0xAA @0xA → resp_valid 2 cycles after each accept. Log words are 0x11223344, then 0x11AA3344; pc is echoed.
- Loads from word 0x80FF7F01 @0x0:
  - lb @0x3 → 0xFFFFFF80; lbu @0x3 → 0x00000080
  - lh @0x2 → 0xFFFF80FF; lhu @0x0 → 0x00007F01
- Misaligned accesses: lw @0x2, sh @0x1, size 3 → resp_err = 1 and rdata = 0; no wr_log_valid and memory unchanged on readback.
- WAIT_CYCLES = 3: accept → resp 5 cycles later. Reset is pulsed 2 cycles after accepting a store → that word still reads 0 after the clear.
- DEPTH = 16: store 0xDEADBEEF @0x44 then load @0x04 → 0xDEADBEEF (wrap); wr_log_addr = 0x44.

Source files
------------

// File: rtl/dm_lsu_if.sv
// dm_lsu_if: request/response and store-trace bundle for the MEM-stage memory.
// Master drives requests; slave is the memory.
interface dm_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        wr_log_valid;
  logic [31:0] wr_log_pc;
  logic [31:0] wr_log_addr;
  logic [31:0] wr_log_data;

  modport master (
    output req_valid, req_we, req_size, req_unsigned,
    output req_addr, req_wdata, req_pc,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  wr_log_valid, wr_log_pc, wr_log_addr, wr_log_data
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned,
    input  req_addr, req_wdata, req_pc,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output wr_log_valid, wr_log_pc, wr_log_addr, wr_log_data
  );
endinterface

// File: rtl/dm_lsu.sv
// dm_lsu: handshaked byte/half/word data memory for the MEM stage.
// Hardware clear after reset, wait-state latency, store trace port.
module dm_lsu #(
  parameter int DEPTH          = 1024,
  parameter int WAIT_CYCLES    = 0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic    clk,
  input  logic    rst,
  dm_lsu_if.slave bus
);
  localparam int AW = $clog2(DEPTH) + 2;
  localparam int IW = AW - 2;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    cnt_q, cnt_d;

  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   pc_q;

  logic          resp_valid_q;
  logic          resp_err_q;
  logic [31:0]   resp_rdata_q;
  logic          log_valid_q;
  logic [31:0]   log_pc_q;
  logic [31:0]   log_addr_q;
  logic [31:0]   log_data_q;

  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          access;
  logic          mem_we;
  logic [IW-1:0] mem_idx;
  logic [31:0]   mem_wd;

  logic [IW-1:0] widx;
  logic [31:0]   old_w;
  logic [31:0]   wrep;
  logic [31:0]   merged_w;
  logic [31:0]   load_w;
  logic [3:0]    lane_en;
  logic          misalign;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;

  // Lane merge for stores and extension for loads off the latched request
  always_comb begin
    widx     = addr_q[AW-1:2];
    old_w    = mem[widx];
    misalign = (size_q == 2'd3)
             | ((size_q == 2'd2) && (addr_q[1:0] != 2'b00))
             | ((size_q == 2'd1) && addr_q[0]);
    lane_en  = 4'b0000;
    wrep     = wdata_q;
    unique case (size_q)
      2'd0: begin
        lane_en = 4'b0001 << addr_q[1:0];
        wrep    = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
        wrep    = {2{wdata_q[15:0]}};
      end
      2'd2:    lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
    merged_w = old_w;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) merged_w[8*i +: 8] = wrep[8*i +: 8];
    end
    ld_b   = old_w[{addr_q[1:0], 3'b000} +: 8];
    ld_h   = addr_q[1] ? old_w[31:16] : old_w[15:0];
    load_w = old_w;
    unique case (size_q)
      2'd0:    load_w = {{24{~uns_q & ld_b[7]}}, ld_b};
      2'd1:    load_w = {{16{~uns_q & ld_h[15]}}, ld_h};
      default: load_w = old_w;
    endcase
  end

  // Next state: clear sweep, request acceptance, wait countdown
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    mem_we  = 1'b0;
    mem_idx = widx;
    mem_wd  = merged_w;
    unique case (state_q)
      S_CLEAR: begin
        mem_we  = 1'b1;
        mem_idx = idx_q;
        mem_wd  = 32'h0;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(DEPTH - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          mem_we  = we_q & ~misalign;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (CLEAR_ON_RESET) state_q <= S_CLEAR;
      else                state_q <= S_IDLE;
      idx_q <= '0;
      cnt_q <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields captured on acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      pc_q    <= 32'h0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      size_q  <= bus.req_size;
      uns_q   <= bus.req_unsigned;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      pc_q    <= bus.req_pc;
    end
  end

  // Response and store-trace registers, loaded at the access edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      log_valid_q  <= 1'b0;
      log_pc_q     <= 32'h0;
      log_addr_q   <= 32'h0;
      log_data_q   <= 32'h0;
    end else begin
      resp_valid_q <= access;
      log_valid_q  <= access & we_q & ~misalign;
      if (access) begin
        resp_err_q   <= misalign;
        resp_rdata_q <= (we_q | misalign) ? 32'h0 : load_w;
      end
      if (access & we_q & ~misalign) begin
        log_pc_q   <= pc_q;
        log_addr_q <= {addr_q[31:2], 2'b00};
        log_data_q <= merged_w;
      end
    end
  end

  // Storage array; reset never writes it, only the clear sweep does
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_idx] <= mem_wd;
  end

  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.resp_rdata   = resp_rdata_q;
  assign bus.wr_log_valid = log_valid_q;
  assign bus.wr_log_pc    = log_pc_q;
  assign bus.wr_log_addr  = log_addr_q;
  assign bus.wr_log_data  = log_data_q;
endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: scoreboard bench for two dm_lsu instances
// (A: 0 wait states, B: 3 wait states, both DEPTH 16 with clear).
module tb_dm_lsu;
  logic clk   = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic        va = 1'b0;
  logic        vb = 1'b0;
  logic        r_we = 1'b0;
  logic [1:0]  r_size = 2'd0;
  logic        r_uns = 1'b0;
  logic [31:0] r_addr = 32'h0;
  logic [31:0] r_wdata = 32'h0;
  logic [31:0] r_pc = 32'h0;

  dm_lsu_if ia ();
  dm_lsu_if ib ();

  assign ia.req_valid    = va;
  assign ia.req_we       = r_we;
  assign ia.req_size     = r_size;
  assign ia.req_unsigned = r_uns;
  assign ia.req_addr     = r_addr;
  assign ia.req_wdata    = r_wdata;
  assign ia.req_pc       = r_pc;
  assign ib.req_valid    = vb;
  assign ib.req_we       = r_we;
  assign ib.req_size     = r_size;
  assign ib.req_unsigned = r_uns;
  assign ib.req_addr     = r_addr;
  assign ib.req_wdata    = r_wdata;
  assign ib.req_pc       = r_pc;

  dm_lsu #(.DEPTH(16), .WAIT_CYCLES(0), .CLEAR_ON_RESET(1'b1)) u_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ia)
  );

  dm_lsu #(.DEPTH(16), .WAIT_CYCLES(3), .CLEAR_ON_RESET(1'b1)) u_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ib)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        logv;
    logic [31:0] pc;
    logic [31:0] laddr;
    logic [31:0] ldata;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int sel, input logic rv, input logic [31:0] rd,
                     input logic er, input logic lv, input logic [31:0] lp,
                     input logic [31:0] la, input logic [31:0] ld);
    exp_t  e;
    int    sz;
    string p;
    p  = (sel == 0) ? "A" : "B";
    sz = (sel == 0) ? qa.size() : qb.size();
    if (lv) chk({p, "_log_with_resp"}, {31'b0, rv}, 32'd1);
    if (rv) begin
      chk({p, "_resp_expected"}, {31'b0, sz != 0}, 32'd1);
      if (sz != 0) begin
        if (sel == 0) e = qa.pop_front();
        else          e = qb.pop_front();
        chk({p, "_latency_cycle"}, cyc, e.due);
        chk({p, "_rdata"}, rd, e.rdata);
        chk({p, "_err"}, {31'b0, er}, {31'b0, e.err});
        chk({p, "_log_valid"}, {31'b0, lv}, {31'b0, e.logv});
        if (e.logv) begin
          chk({p, "_log_pc"}, lp, e.pc);
          chk({p, "_log_addr"}, la, e.laddr);
          chk({p, "_log_data"}, ld, e.ldata);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, ia.resp_valid, ia.resp_rdata, ia.resp_err, ia.wr_log_valid,
        ia.wr_log_pc, ia.wr_log_addr, ia.wr_log_data);
  end

  always @(posedge clk) begin
    #1;
    mon(1, ib.resp_valid, ib.resp_rdata, ib.resp_err, ib.wr_log_valid,
        ib.wr_log_pc, ib.wr_log_addr, ib.wr_log_data);
  end

  task automatic issue(input int sel, input logic we, input logic [1:0] sz,
                       input logic un, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [31:0] pc,
                       input logic [31:0] xr, input logic xe, input logic xl,
                       input logic [31:0] xd, input bit track);
    int   n;
    logic rdy;
    logic ok;
    exp_t e;
    @(negedge clk);
    r_we = we; r_size = sz; r_uns = un;
    r_addr = ad; r_wdata = wd; r_pc = pc;
    if (sel == 0) va = 1'b1;
    else          vb = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 100) begin
      rdy = (sel == 0) ? ia.req_ready : ib.req_ready;
      @(posedge clk);
      if (rdy === 1'b1) ok = 1'b1;
      else              @(negedge clk);
      n++;
    end
    #1;
    va = 1'b0;
    vb = 1'b0;
    chk("accept_in_budget", {31'b0, ok}, 32'd1);
    if (ok && track) begin
      e.rdata = xr;
      e.err   = xe;
      e.logv  = xl;
      e.pc    = pc;
      e.laddr = {ad[31:2], 2'b00};
      e.ldata = xd;
      e.due   = cyc + 1 + ((sel == 0) ? 0 : 3);
      if (sel == 0) qa.push_back(e);
      else          qb.push_back(e);
    end
  endtask

  task automatic drain(input int sel);
    int n;
    n = 0;
    while (((sel == 0) ? qa.size() : qb.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", (sel == 0) ? qa.size() : qb.size(), 32'd0);
  endtask

  task automatic chk_reset(input int sel);
    if (sel == 0) begin
      chk("A_rst_ready", {31'b0, ia.req_ready}, 32'd0);
      chk("A_rst_resp_valid", {31'b0, ia.resp_valid}, 32'd0);
      chk("A_rst_resp_err", {31'b0, ia.resp_err}, 32'd0);
      chk("A_rst_rdata", ia.resp_rdata, 32'd0);
      chk("A_rst_log_valid", {31'b0, ia.wr_log_valid}, 32'd0);
      chk("A_rst_log_pc", ia.wr_log_pc, 32'd0);
      chk("A_rst_log_addr", ia.wr_log_addr, 32'd0);
      chk("A_rst_log_data", ia.wr_log_data, 32'd0);
    end else begin
      chk("B_rst_ready", {31'b0, ib.req_ready}, 32'd0);
      chk("B_rst_resp_valid", {31'b0, ib.resp_valid}, 32'd0);
      chk("B_rst_log_valid", {31'b0, ib.wr_log_valid}, 32'd0);
      chk("B_rst_log_data", ib.wr_log_data, 32'd0);
    end
  endtask

  task automatic time_clear(output int na, output int nb);
    na = -1;
    nb = -1;
    for (int i = 0; i < 40; i++) begin
      if (na < 0 && ia.req_ready === 1'b1) na = i;
      if (nb < 0 && ib.req_ready === 1'b1) nb = i;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int na;
    int nb;
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst_a = 1'b0;
    rst_b = 1'b0;
    time_clear(na, nb);
    chk("A_clear_cycles", na, 32'd16);
    chk("B_clear_cycles", nb, 32'd16);

    // garbage, then reset A and confirm the clear wiped it
    issue(0, 1, 2'd2, 0, 32'h3C, 32'hCAFEF00D, 32'h10, 32'h0, 0, 1, 32'hCAFEF00D, 1);
    drain(0);
    @(negedge clk);
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset(0);
    rst_a = 1'b0;
    time_clear(na, nb);
    chk("A_reclear_cycles", na, 32'd16);
    issue(0, 0, 2'd2, 0, 32'h3C, 32'h0, 32'h14, 32'h0, 0, 0, 32'h0, 1);

    // store merge and trace
    issue(0, 1, 2'd2, 0, 32'h8, 32'h11223344, 32'h100, 32'h0, 0, 1, 32'h11223344, 1);
    issue(0, 1, 2'd0, 0, 32'hA, 32'h000000AA, 32'h104, 32'h0, 0, 1, 32'h11AA3344, 1);
    issue(0, 0, 2'd2, 0, 32'h8, 32'h0, 32'h108, 32'h11AA3344, 0, 0, 32'h0, 1);

    // load extension
    issue(0, 1, 2'd2, 0, 32'h0, 32'h80FF7F01, 32'h10C, 32'h0, 0, 1, 32'h80FF7F01, 1);
    issue(0, 0, 2'd0, 0, 32'h3, 32'h0, 32'h110, 32'hFFFFFF80, 0, 0, 32'h0, 1);
    issue(0, 0, 2'd0, 1, 32'h3, 32'h0, 32'h114, 32'h00000080, 0, 0, 32'h0, 1);
    issue(0, 0, 2'd1, 0, 32'h2, 32'h0, 32'h118, 32'hFFFF80FF, 0, 0, 32'h0, 1);
    issue(0, 0, 2'd1, 1, 32'h0, 32'h0, 32'h11C, 32'h00007F01, 0, 0, 32'h0, 1);
    issue(0, 0, 2'd0, 0, 32'h1, 32'h0, 32'h120, 32'h0000007F, 0, 0, 32'h0, 1);

    // misaligned and reserved size
    issue(0, 0, 2'd2, 0, 32'h2, 32'h0, 32'h124, 32'h0, 1, 0, 32'h0, 1);
    issue(0, 1, 2'd1, 0, 32'h1, 32'h5555, 32'h128, 32'h0, 1, 0, 32'h0, 1);
    issue(0, 1, 2'd3, 0, 32'h0, 32'hFFFFFFFF, 32'h12C, 32'h0, 1, 0, 32'h0, 1);
    issue(0, 0, 2'd2, 0, 32'h0, 32'h0, 32'h130, 32'h80FF7F01, 0, 0, 32'h0, 1);

    // address wrap and half merge in upper lanes
    issue(0, 1, 2'd2, 0, 32'h44, 32'hDEADBEEF, 32'h200, 32'h0, 0, 1, 32'hDEADBEEF, 1);
    issue(0, 0, 2'd2, 0, 32'h04, 32'h0, 32'h204, 32'hDEADBEEF, 0, 0, 32'h0, 1);
    issue(0, 1, 2'd1, 0, 32'h6, 32'h1234, 32'h208, 32'h0, 0, 1, 32'h1234BEEF, 1);
    issue(0, 0, 2'd1, 1, 32'h6, 32'h0, 32'h20C, 32'h00001234, 0, 0, 32'h0, 1);
    issue(0, 0, 2'd1, 0, 32'h4, 32'h0, 32'h210, 32'hFFFFBEEF, 0, 0, 32'h0, 1);
    drain(0);

    // wait-state instance
    issue(1, 1, 2'd2, 0, 32'h10, 32'h12345678, 32'h300, 32'h0, 0, 1, 32'h12345678, 1);
    issue(1, 0, 2'd2, 0, 32'h10, 32'h0, 32'h304, 32'h12345678, 0, 0, 32'h0, 1);
    drain(1);

    // reset mid-wait abandons the store
    issue(1, 1, 2'd2, 0, 32'h20, 32'hA5A5A5A5, 32'h308, 32'h0, 0, 1, 32'hA5A5A5A5, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset(1);
    rst_b = 1'b0;
    time_clear(na, nb);
    chk("B_reclear_cycles", nb, 32'd16);
    issue(1, 0, 2'd2, 0, 32'h20, 32'h0, 32'h30C, 32'h0, 0, 0, 32'h0, 1);
    drain(1);
    drain(0);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
